alu_input_loader: RTL and testbench

//  Front-end for the ALU: debounces three board push-buttons and latches operand A,

---
 rtl/alu_input_loader_pkg.sv | 25 ++
 rtl/alu_input_loader_if.sv | 29 ++
 rtl/alu_input_loader_btn_debounce.sv | 43 ++++
 rtl/alu_input_loader.sv | 109 ++++++++++
 tb/tb_alu_input_loader.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/alu_input_loader_pkg.sv
// Shared widths, ALU opcode constants and loader FSM encodings for the ALU input loader.
package alu_input_loader_pkg;

  localparam int unsigned DATA_SIZE_DEF       = 8;
  localparam int unsigned OP_SIZE_DEF         = 6;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 100000;
  localparam int unsigned LOADED_W            = 3;

  localparam logic [OP_SIZE_DEF-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_SIZE_DEF-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_SIZE_DEF-1:0] OP_AND = 6'b100100;
  localparam logic [OP_SIZE_DEF-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_SIZE_DEF-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_SIZE_DEF-1:0] OP_NOR = 6'b100111;
  localparam logic [OP_SIZE_DEF-1:0] OP_SRA = 6'b000011;
  localparam logic [OP_SIZE_DEF-1:0] OP_SRL = 6'b000010;

  typedef enum logic [1:0] {
    ST_WAIT_A  = 2'd0,
    ST_WAIT_B  = 2'd1,
    ST_WAIT_OP = 2'd2,
    ST_LOADED  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/alu_input_loader_if.sv
// Switch/button inputs and latched ALU operand outputs of the loader.
interface alu_input_loader_if
  import alu_input_loader_pkg::*;
#(
  parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
  parameter int unsigned OP_SIZE   = OP_SIZE_DEF
);

  logic [DATA_SIZE-1:0] i_sw;
  logic                 i_btn_a;
  logic                 i_btn_b;
  logic                 i_btn_op;
  logic [DATA_SIZE-1:0] o_a;
  logic [DATA_SIZE-1:0] o_b;
  logic [OP_SIZE-1:0]   o_op;
  logic [LOADED_W-1:0]  o_loaded;
  logic                 o_valid;

  modport master (
    output i_sw, i_btn_a, i_btn_b, i_btn_op,
    input  o_a, o_b, o_op, o_loaded, o_valid
  );

  modport slave (
    input  i_sw, i_btn_a, i_btn_b, i_btn_op,
    output o_a, o_b, o_op, o_loaded, o_valid
  );

endinterface

// File: rtl/alu_input_loader_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-level debouncer, one-cycle press pulse.
module alu_input_loader_btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             stable_q;
  logic [CNT_W-1:0] cnt_q;

  // Counter only runs while the synchronized level disagrees with the accepted one.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync_q1  <= 1'b0;
      sync_q2  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      o_press  <= 1'b0;
    end else begin
      sync_q1 <= i_btn;
      sync_q2 <= sync_q1;
      o_press <= 1'b0;
      if (sync_q2 == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= sync_q2;
        cnt_q    <= '0;
        o_press  <= sync_q2;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_input_loader.sv
// Debounces three buttons and latches operand A, operand B and opcode from the switches.
// ALU_LOADER_STRICT_ORDER_EN: enforce A -> B -> OP load order with a 4-state FSM.
module alu_input_loader
  import alu_input_loader_pkg::*;
#(
  parameter int unsigned DATA_SIZE       = DATA_SIZE_DEF,
  parameter int unsigned OP_SIZE         = OP_SIZE_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic               i_clk,
  input  logic               i_reset,
  alu_input_loader_if.slave  bus
);

  logic press_a;
  logic press_b;
  logic press_op;

  alu_input_loader_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .i_clk(i_clk), .i_reset(i_reset), .i_btn(bus.i_btn_a), .o_press(press_a)
  );

  alu_input_loader_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .i_clk(i_clk), .i_reset(i_reset), .i_btn(bus.i_btn_b), .o_press(press_b)
  );

  alu_input_loader_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_op (
    .i_clk(i_clk), .i_reset(i_reset), .i_btn(bus.i_btn_op), .o_press(press_op)
  );

  logic [OP_SIZE-1:0] sw_op_c;
  assign sw_op_c = bus.i_sw[OP_SIZE-1:0];

`ifdef ALU_LOADER_STRICT_ORDER_EN

  loader_state_e state_q;

  // Only the press expected by the current state is captured; others are dropped.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_WAIT_A;
      bus.o_a      <= '0;
      bus.o_b      <= '0;
      bus.o_op     <= '0;
      bus.o_loaded <= 3'b000;
      bus.o_valid  <= 1'b0;
    end else begin
      case (state_q)
        ST_WAIT_A, ST_LOADED: begin
          if (press_a) begin
            bus.o_a      <= bus.i_sw;
            state_q      <= ST_WAIT_B;
            bus.o_loaded <= 3'b001;
            bus.o_valid  <= 1'b0;
          end
        end
        ST_WAIT_B: begin
          if (press_b) begin
            bus.o_b      <= bus.i_sw;
            state_q      <= ST_WAIT_OP;
            bus.o_loaded <= 3'b011;
            bus.o_valid  <= 1'b0;
          end
        end
        ST_WAIT_OP: begin
          if (press_op) begin
            bus.o_op     <= sw_op_c;
            state_q      <= ST_LOADED;
            bus.o_loaded <= 3'b111;
            bus.o_valid  <= 1'b1;
          end
        end
        default: begin
          state_q      <= ST_WAIT_A;
          bus.o_loaded <= 3'b000;
          bus.o_valid  <= 1'b0;
        end
      endcase
    end
  end

`else

  logic [LOADED_W-1:0] loaded_nxt_c;

  always_comb begin
    loaded_nxt_c = bus.o_loaded | {press_op, press_b, press_a};
  end

  // Independent captures; flags are sticky so o_valid stays set until reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      bus.o_a      <= '0;
      bus.o_b      <= '0;
      bus.o_op     <= '0;
      bus.o_loaded <= 3'b000;
      bus.o_valid  <= 1'b0;
    end else begin
      if (press_a)  bus.o_a  <= bus.i_sw;
      if (press_b)  bus.o_b  <= bus.i_sw;
      if (press_op) bus.o_op <= sw_op_c;
      bus.o_loaded <= loaded_nxt_c;
      bus.o_valid  <= &loaded_nxt_c;
    end
  end

`endif

endmodule

// File: tb/tb_alu_input_loader.sv
// Directed bench for alu_input_loader with DEBOUNCE_CYCLES=4; covers the build selected by ALU_LOADER_STRICT_ORDER_EN.
module tb_alu_input_loader;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  alu_input_loader_if #(.DATA_SIZE(8), .OP_SIZE(6)) bus ();

  alu_input_loader #(.DATA_SIZE(8), .OP_SIZE(6), .DEBOUNCE_CYCLES(4)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
  endtask

  // Hold the selected buttons well past the debounce window, then release and settle.
  task automatic press(input logic a, input logic b, input logic op, input logic [7:0] sw);
    bus.i_sw     = sw;
    bus.i_btn_a  = a;
    bus.i_btn_b  = b;
    bus.i_btn_op = op;
    tick(10);
    bus.i_btn_a  = 1'b0;
    bus.i_btn_b  = 1'b0;
    bus.i_btn_op = 1'b0;
    tick(10);
  endtask

  initial begin
    n_assert     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.i_sw     = 8'h00;
    bus.i_btn_a  = 1'b0;
    bus.i_btn_b  = 1'b0;
    bus.i_btn_op = 1'b0;
    tick(3);

    check("rst_a",      32'(bus.o_a),      32'h00);
    check("rst_b",      32'(bus.o_b),      32'h00);
    check("rst_op",     32'(bus.o_op),     32'h00);
    check("rst_loaded", 32'(bus.o_loaded), 32'h0);
    check("rst_valid",  32'(bus.o_valid),  32'h0);
    rst = 1'b0;
    tick(2);

    // Load A with exact latency: 2 sync + 4 debounce + 1 capture edges
    bus.i_sw    = 8'h12;
    bus.i_btn_a = 1'b1;
    tick(6);
    check("t1_a_early", 32'(bus.o_a), 32'h00);
    tick(1);
    check("t1_a", 32'(bus.o_a), 32'h12);
    tick(3);
    bus.i_btn_a = 1'b0;
    tick(10);
    check("t1_loaded", 32'(bus.o_loaded), 32'h1);
    check("t1_valid",  32'(bus.o_valid),  32'h0);

    // Bounce: toggle every 2 cycles, never stable for 4
    bus.i_sw = 8'hFF;
    repeat (5) begin
      bus.i_btn_a = 1'b1;
      tick(2);
      bus.i_btn_a = 1'b0;
      tick(2);
    end
    tick(10);
    check("t2_a",      32'(bus.o_a),      32'h12);
    check("t2_loaded", 32'(bus.o_loaded), 32'h1);

`ifdef ALU_LOADER_STRICT_ORDER_EN
    do_reset();
    press(1'b0, 1'b1, 1'b0, 8'h55);
    check("t5_b_drop_loaded", 32'(bus.o_loaded), 32'h0);
    check("t5_b_drop_b",      32'(bus.o_b),      32'h00);
    press(1'b1, 1'b0, 1'b0, 8'h11);
    check("t5_a_loaded", 32'(bus.o_loaded), 32'h1);
    press(1'b0, 1'b1, 1'b0, 8'h22);
    check("t5_b_loaded", 32'(bus.o_loaded), 32'h3);
    check("t5_b_valid",  32'(bus.o_valid),  32'h0);
    press(1'b0, 1'b0, 1'b1, 8'h25);
    check("t5_op_loaded", 32'(bus.o_loaded), 32'h7);
    check("t5_op_valid",  32'(bus.o_valid),  32'h1);
    check("t5_op",        32'(bus.o_op),     32'h25);
    press(1'b1, 1'b0, 1'b0, 8'h33);
    check("t5_rea_valid",  32'(bus.o_valid),  32'h0);
    check("t5_rea_loaded", 32'(bus.o_loaded), 32'h1);
    check("t5_rea_a",      32'(bus.o_a),      32'h33);
    check("t5_rea_b",      32'(bus.o_b),      32'h22);
    press(1'b1, 1'b1, 1'b0, 8'h44);
    check("t5_sim_a",      32'(bus.o_a),      32'h33);
    check("t5_sim_b",      32'(bus.o_b),      32'h44);
    check("t5_sim_loaded", 32'(bus.o_loaded), 32'h3);
`else
    do_reset();
    press(1'b0, 1'b0, 1'b1, 8'h20);
    check("t3_op_loaded", 32'(bus.o_loaded), 32'h4);
    check("t3_op_valid",  32'(bus.o_valid),  32'h0);
    press(1'b0, 1'b1, 1'b0, 8'h05);
    check("t3_b_valid",   32'(bus.o_valid),  32'h0);
    press(1'b1, 1'b0, 1'b0, 8'h07);
    check("t3_valid",  32'(bus.o_valid),  32'h1);
    check("t3_loaded", 32'(bus.o_loaded), 32'h7);
    check("t3_op",     32'(bus.o_op),     32'h20);
    check("t3_b",      32'(bus.o_b),      32'h05);
    check("t3_a",      32'(bus.o_a),      32'h07);
    press(1'b0, 1'b0, 1'b1, 8'hE3);
    check("t3_op_trunc",  32'(bus.o_op),    32'h23);
    check("t3_valid_hold", 32'(bus.o_valid), 32'h1);

    do_reset();
    press(1'b1, 1'b1, 1'b0, 8'h3C);
    check("t4_a",      32'(bus.o_a),      32'h3C);
    check("t4_b",      32'(bus.o_b),      32'h3C);
    check("t4_loaded", 32'(bus.o_loaded), 32'h3);
    check("t4_valid",  32'(bus.o_valid),  32'h0);
`endif

    // Reset mid-debounce with the button held; release reset and keep holding
    do_reset();
    bus.i_sw    = 8'h99;
    bus.i_btn_a = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(2);
    check("t6_rst_a",      32'(bus.o_a),      32'h00);
    check("t6_rst_loaded", 32'(bus.o_loaded), 32'h0);
    check("t6_rst_valid",  32'(bus.o_valid),  32'h0);
    rst = 1'b0;
    tick(6);
    check("t6_a_early", 32'(bus.o_a), 32'h00);
    tick(1);
    check("t6_a",      32'(bus.o_a),      32'h99);
    check("t6_loaded", 32'(bus.o_loaded), 32'h1);
    bus.i_btn_a = 1'b0;
    tick(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
